// File: rtl/min_distance_tracker.sv
// min_distance_tracker: nearest-point reduction after the Manhattan
// distance unit; tracks running minimum, its index and query flags.
module min_distance_tracker #(
  parameter int IDX_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [3:0]       dist_high,
  input  logic [3:0]       dist_low,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       min_high,
  output logic [3:0]       min_low,
  output logic [IDX_W-1:0] min_idx,
  output logic [IDX_W:0]   count,
  output logic             zero_hit,
  output logic             trunc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W:0] CAP_M1 = {1'b0, {IDX_W{1'b1}}};

  state_t     state;
  logic [7:0] min_q;
  logic [7:0] d;
  logic       accept;
  logic       cap_hit;

  assign d         = {dist_high, dist_low};
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign min_high  = min_q[7:4];
  assign min_low   = min_q[3:0];
  assign accept    = in_valid & in_ready;
  assign cap_hit   = (count == CAP_M1);

  // query FSM plus running-minimum datapath; start overrides everything
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      min_q    <= 8'hFF;
      min_idx  <= '0;
      count    <= '0;
      zero_hit <= 1'b0;
      trunc    <= 1'b0;
    end else if (ena) begin
      if (start) begin
        state    <= ACCUM;
        min_q    <= 8'hFF;
        min_idx  <= '0;
        count    <= '0;
        zero_hit <= 1'b0;
        trunc    <= 1'b0;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              if (d < min_q) begin
                min_q   <= d;
                min_idx <= count[IDX_W-1:0];
              end
              if (d == 8'h00) zero_hit <= 1'b1;
              count <= count + 1'b1;
              if (in_last) begin
                state <= DONE;
                trunc <= 1'b0;
              end else if (cap_hit) begin
                state <= DONE;
                trunc <= 1'b1;
              end
            end
          end
          DONE: begin
            if (out_ready) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_min_distance_tracker.sv
// tb_min_distance_tracker: directed scenario bench for the
// nearest-point tracker (IDX_W = 4).
module tb_min_distance_tracker;

  localparam int IDX_W = 4;

  logic             clk;
  logic             rst_n;
  logic             ena;
  logic             start;
  logic             in_valid;
  logic             in_ready;
  logic             in_last;
  logic [3:0]       dist_high;
  logic [3:0]       dist_low;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       min_high;
  logic [3:0]       min_low;
  logic [IDX_W-1:0] min_idx;
  logic [IDX_W:0]   count;
  logic             zero_hit;
  logic             trunc;

  int vectors;
  int miscompares;

  min_distance_tracker #(.IDX_W(IDX_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_last  (in_last),
    .dist_high(dist_high),
    .dist_low (dist_low),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .min_high (min_high),
    .min_low  (min_low),
    .min_idx  (min_idx),
    .count    (count),
    .zero_hit (zero_hit),
    .trunc    (trunc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {in_ready, out_valid, min[7:0], min_idx, count, zero_hit, trunc}
  function automatic logic [20:0] obs();
    return {in_ready, out_valid, min_high, min_low,
            min_idx, count, zero_hit, trunc};
  endfunction

  function automatic logic [20:0] exp_v(
    input logic       rdy,
    input logic       vld,
    input logic [7:0] mn,
    input logic [3:0] idx,
    input logic [4:0] cnt,
    input logic       zh,
    input logic       tr
  );
    return {rdy, vld, mn, idx, cnt, zh, tr};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start     = 1'b0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    dist_high = 4'h0;
    dist_low  = 4'h0;
    out_ready = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] v, input logic last);
    in_valid  = 1'b1;
    in_last   = last;
    dist_high = v[7:4];
    dist_low  = v[3:0];
    tick();
    in_valid  = 1'b0;
    in_last   = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    e = exp_v(0, 0, 8'hFF, 0, 0, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_init got %h want %h", obs(), e);
    end
    do_start();
    beat(8'd10, 0);
    beat(8'd11, 0);
    beat(8'd12, 0);
    e = exp_v(1, 0, 8'd10, 0, 3, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_pre got %h want %h", obs(), e);
    end
    #2 rst_n = 1'b0;
    #1;
    e = exp_v(0, 0, 8'hFF, 0, 0, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_async got %h want %h", obs(), e);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1;
    dist_low = 4'h3;
    tick();
    tick();
    in_valid = 1'b0;
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL reset_idle got %h want %h", obs(), e);
    end
  endtask

  task automatic test_basic();
    logic [20:0] e;
    do_start();
    e = exp_v(1, 0, 8'hFF, 0, 0, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL basic_start got %h want %h", obs(), e);
    end
    beat(8'd12, 0);
    beat(8'd5, 0);
    e = exp_v(1, 0, 8'd5, 1, 2, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL basic_mid got %h want %h", obs(), e);
    end
    beat(8'd9, 0);
    beat(8'd5, 1);
    e = exp_v(0, 1, 8'd5, 1, 4, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL basic_done got %h want %h", obs(), e);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    e = exp_v(0, 0, 8'd5, 1, 4, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL basic_idle got %h want %h", obs(), e);
    end
  endtask

  task automatic test_zero();
    logic [20:0] e;
    do_start();
    beat(8'd30, 0);
    tick();
    e = exp_v(1, 0, 8'd30, 0, 1, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL zero_gap got %h want %h", obs(), e);
    end
    beat(8'd0, 0);
    tick();
    tick();
    e = exp_v(1, 0, 8'd0, 1, 2, 1, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL zero_hit got %h want %h", obs(), e);
    end
    beat(8'd22, 1);
    e = exp_v(0, 1, 8'd0, 1, 3, 1, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL zero_done got %h want %h", obs(), e);
    end
  endtask

  task automatic test_capacity();
    logic [20:0] e;
    do_start();
    for (int i = 0; i < 15; i++) beat(8'(20 - i), 0);
    e = exp_v(1, 0, 8'd6, 14, 15, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL cap_15 got %h want %h", obs(), e);
    end
    beat(8'd5, 0);
    e = exp_v(0, 1, 8'd5, 15, 16, 0, 1);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL cap_full got %h want %h", obs(), e);
    end
    beat(8'd1, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL cap_17th got %h want %h", obs(), e);
    end
  endtask

  task automatic test_handshake_ena();
    logic [20:0] e;
    e = exp_v(0, 1, 8'd5, 15, 16, 0, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++;
      if (obs() !== e) begin
        miscompares++;
        $display("FAIL hold_%0d got %h want %h", i, obs(), e);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    e = exp_v(0, 0, 8'd5, 15, 16, 0, 1);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL hs_idle got %h want %h", obs(), e);
    end
    do_start();
    beat(8'd7, 0);
    ena       = 1'b0;
    in_valid  = 1'b1;
    dist_high = 4'h0;
    dist_low  = 4'h3;
    tick();
    tick();
    tick();
    e = exp_v(1, 0, 8'd7, 0, 1, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL ena_hold got %h want %h", obs(), e);
    end
    ena     = 1'b1;
    in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    e = exp_v(0, 1, 8'd3, 1, 2, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL ena_done got %h want %h", obs(), e);
    end
    ena       = 1'b0;
    out_ready = 1'b1;
    tick();
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL ena_out got %h want %h", obs(), e);
    end
    ena = 1'b1;
    tick();
    out_ready = 1'b0;
    e = exp_v(0, 0, 8'd3, 1, 2, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL ena_idle got %h want %h", obs(), e);
    end
  endtask

  task automatic test_priority();
    logic [20:0] e;
    do_start();
    beat(8'd4, 1);
    start     = 1'b1;
    in_valid  = 1'b1;
    dist_high = 4'h0;
    dist_low  = 4'h1;
    out_ready = 1'b1;
    tick();
    e = exp_v(1, 0, 8'hFF, 0, 0, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL prio_done got %h want %h", obs(), e);
    end
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL prio_accum got %h want %h", obs(), e);
    end
    beat(8'd2, 1);
    e = exp_v(0, 1, 8'd2, 0, 1, 0, 0);
    vectors++;
    if (obs() !== e) begin
      miscompares++;
      $display("FAIL prio_after got %h want %h", obs(), e);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    ena         = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_basic();
    test_zero();
    test_capacity();
    test_handshake_ena();
    test_priority();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/min_distance_tracker.md
# min_distance_tracker

Streaming reduction stage directly downstream of the vector Manhattan distance unit in the Mini SPU. It accepts one 8-bit distance per handshake (supplied as high/low nibbles exactly as the distance unit produces them), tracks the running minimum and the index of the point that produced it, and presents a registered nearest-point result once the query's last point arrives. It turns the per-pair combinational distance into a nearest-neighbour query over up to 2^IDX_W points.

## Interface
- IDX_W, default 4: width of point index and counter; max points per query = 2^IDX_W.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  clock enable; low freezes all state and outputs.
- start  in  1  begin a new query (one-cycle pulse; level is sampled every enabled cycle).
- in_valid  in  1  distance beat present.
- in_ready  out  1  tracker can accept a beat.
- in_last  in  1  beat is the final point of the query.
- dist_high  in  4  distance bits [7:4].
- dist_low  in  4  distance bits [3:0].
- out_valid  out  1  result is valid and held.
- out_ready  in  1  consumer accepts result.
- min_high  out  4  minimum distance bits [7:4].
- min_low  out  4  minimum distance bits [3:0].
- min_idx  out  IDX_W  index (0-based arrival order) of minimum point.
- count  out  IDX_W+1  number of beats accepted in current query.
- zero_hit  out  1  some accepted beat had distance 0.
- trunc  out  1  query closed by capacity, not by in_last.

## Operation
- Reset values: state IDLE, in_ready 0, out_valid 0, min_high/min_low 4'hF/4'hF, min_idx 0, count 0, zero_hit 0, trunc 0.
- States: IDLE, ACCUM, DONE. in_ready = (state==ACCUM); out_valid = (state==DONE); both derived from registered state only.
- start (any state, ena=1): next state ACCUM; min←8'hFF, min_idx←0, count←0, zero_hit←0, trunc←0. start wins over a same-cycle in_valid beat (beat not accepted, since in_ready is 0 or is overridden) and over same-cycle out_ready.
- ACCUM, accept = in_valid & in_ready: d = {dist_high, dist_low}, compared unsigned 8-bit.
  - d < min (strict): min←d, min_idx←count[IDX_W-1:0]. Ties keep earlier index.
  - d == 0: zero_hit←1.
  - count←count+1.
  - in_last=1 on accepted beat: → DONE, trunc←0.
  - in_last=0 and count == 2^IDX_W-1 before increment (capacity-filling beat): → DONE, trunc←1.
- ACCUM with no accept: hold.
- DONE: outputs held stable; out_ready=1 → IDLE (result registers keep their values in IDLE until next start). 
- IDLE: in_ready 0, out_valid 0; out_ready ignored; beats ignored.
- Query with zero beats cannot complete; abandoned only by start or reset.
- ena=0: no state, counter or output register changes; handshakes not taken (in_ready/out_valid still reflect held state but a transfer only counts when ena=1).
- rst_n asserted at any time, including mid-query or in DONE: immediate return to reset values, no result emitted.

## Timing
- All outputs registered; no combinational path input→output.
- start at edge N → in_ready high after edge N.
- Beat accepted at edge N updates min/min_idx/count visible after edge N.
- Last beat at edge N → out_valid high after edge N, result includes that beat (1-cycle latency).
- out_ready sampled at edge M with out_valid high → out_valid low after edge M.
- Back-to-back beats at one per cycle sustained in ACCUM.
- New start in DONE (without out_ready) discards the held result.

## Test plan
- Reset: assert rst_n=0 mid-ACCUM after 3 beats -> all outputs at reset values, in_ready 0, out_valid 0 immediately.
- Basic query: start; beats 12, 5, 9, 5(last) back-to-back -> out_valid next cycle, min 8'h05, min_idx 1 (tie keeps earlier), count 4, zero_hit 0, trunc 0.
- Max/zero: beats 30, 0, 22(last) -> min 0, min_idx 1, zero_hit 1; gaps of in_valid=0 between beats change nothing.
- Capacity (IDX_W=4): 16 beats of 20..5 descending, in_last never set -> DONE after 16th, min 8'h05, min_idx 15, count 16, trunc 1; 17th in_valid not accepted.
- Handshake/ena: hold out_ready=0 for 5 cycles -> result stable; toggle ena=0 during ACCUM with in_valid=1 -> count unchanged; out_ready=1 -> IDLE next cycle.
- Priority: start asserted same cycle as in_valid beat of 1 and in DONE with out_ready=1 -> new query begins, beat dropped, count 0, min 8'hFF.
